instruction_fetch_mips: RTL and testbench

//  Fetch stage between the program counter and decode. Reads the word at ptr

---
 rtl/mips_fetch_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instruction_fetch_mips.sv | 100 ++++++++++
 tb/tb_instruction_fetch_mips.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
// mips_fetch_pkg : opcodes, FSM states and FIFO entry type for the fetch stage.
// FETCH_JAL_EN: when defined, JAL is flagged as a jump alongside J.  Rev 1.0
// ============================================================================
package mips_fetch_pkg;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

`ifdef FETCH_JAL_EN
  localparam bit JAL_IS_JUMP = 1'b1;
`else
  localparam bit JAL_IS_JUMP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DISCARD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_DATA_W-1:0] word;
  } fetch_entry_t;

  function automatic logic opcode_is_jump(input logic [5:0] opc);
    return (opc == OPC_J) || (JAL_IS_JUMP && (opc == OPC_JAL));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous prefetch FIFO of fetch entries; flush beats push/pop.
// Rev 1.0
// ============================================================================
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !flush && (count != CNT_W'(DEPTH));
  assign do_pop   = pop && !flush && (count != '0);
  assign rd_entry = entries[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= wr_entry;
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_mips.sv
`default_nettype none
// ============================================================================
// instruction_fetch_mips : single-outstanding fetch into a prefetch FIFO, with
// J/JAL detection at pop that redirects the PC and flushes prefetched words. Rev 1.0
// ============================================================================
module instruction_fetch_mips
  import mips_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ptr,
  output logic              pc_en,
  output logic              is_jump,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state;
  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             pop;

  assign instr_valid = (fifo_count != '0);
  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop         = instr_valid && instr_ready;
  assign instruction = DATA_W'(rd_entry.word);
  assign instr_pc    = ADDR_W'(rd_entry.addr);
  assign is_jump     = pop && opcode_is_jump(instruction[31:26]);
  // A response landing on a jump edge belongs to the abandoned path.
  assign pc_en       = (state == WAIT_ACK) && mem_ack && !is_jump;

  assign wr_entry.addr = FETCH_ADDR_W'(mem_addr);
  assign wr_entry.word = FETCH_DATA_W'(mem_rdata);

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pc_en),
    .pop      (pop),
    .flush    (is_jump),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ptr is about to be overwritten by a jump target; wait one cycle.
          if (!fifo_full && !is_jump) begin
            mem_req  <= 1'b1;
            mem_addr <= ptr;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (is_jump) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_mips.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch_mips : directed + random fetch scenarios checked against
// a program-trace model and a variable-latency memory responder. Rev 1.0
// ============================================================================
module tb_instruction_fetch_mips;

  localparam int DEPTH = 4;
`ifdef FETCH_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ptr;
  logic        pc_en;
  logic        is_jump;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instruction_fetch_mips #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ptr         (ptr),
    .pc_en       (pc_en),
    .is_jump     (is_jump),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [256];
  int          occ;
  logic [31:0] exp_pc;
  logic [31:0] next_ptr;
  bit          pending;
  int          lat_left;
  logic [31:0] req_addr;
  logic [31:0] req_log [$];
  int          fixed_lat;
  int          max_lat;
  bit          rand_ready;
  int          n_push, n_ack, n_pop, n_jump;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit op_is_jump(input logic [31:0] w);
    return (w[31:26] == 6'd2) || (JAL_EN && (w[31:26] == 6'd3));
  endfunction

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'd2 || w[31:26] == 6'd3) w[31:26] = 6'd8;
    return w;
  endfunction

  // Trace model: decode must see exactly the program order from address 0.
  task automatic sample();
    logic        p;
    logic [31:0] w;
    if (reset) begin
      occ = 0; exp_pc = 0; next_ptr = 0;
      return;
    end
    p = instr_valid && instr_ready;
    check("instr_valid", 32'(instr_valid), 32'(occ != 0));
    if (mem_ack) n_ack++;
    if (p) begin
      w = mem[exp_pc[9:2]];
      check("instr_pc", instr_pc, exp_pc);
      check("instruction", instruction, w);
      check("is_jump_pop", 32'(is_jump), 32'(op_is_jump(w)));
      n_pop++;
      exp_pc = op_is_jump(w) ? {exp_pc[31:28], w[25:0], 2'b00} : exp_pc + 32'd4;
    end else begin
      check("is_jump_nopop", 32'(is_jump), 32'd0);
    end
    if (pc_en) n_push++;
    if (is_jump) begin
      n_jump++;
      occ = 0;
    end else begin
      occ = occ + (pc_en ? 1 : 0) - (p ? 1 : 0);
    end
    check("occupancy_bound", 32'(occ <= DEPTH), 32'd1);
    next_ptr = is_jump ? {ptr[31:28], instruction[25:0], 2'b00} : (pc_en ? ptr + 32'd4 : ptr);
  endtask

  task automatic post_edge(input bit was_reset);
    ptr = next_ptr;
    if (rand_ready) instr_ready = ($urandom_range(0, 3) != 0);
    if (was_reset) begin
      pending = 0;
      mem_ack = 1'b0;
      return;
    end
    if (mem_ack) begin
      pending = 0;
      check("req_drop_after_ack", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    if (pending) begin
      check("req_held", 32'(mem_req), 32'd1);
      check("addr_stable", mem_addr, req_addr);
    end
    if (mem_req) begin
      if (!pending) begin
        pending  = 1;
        req_addr = mem_addr;
        req_log.push_back(mem_addr);
        lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, max_lat));
      end
      if (lat_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
      end else begin
        lat_left--;
        mem_rdata = $urandom;
      end
    end
  endtask

  task automatic step();
    bit r;
    @(negedge clk);
    sample();
    r = reset;
    @(posedge clk);
    #1;
    post_edge(r);
  endtask

  task automatic clear_counts();
    req_log.delete();
    n_push = 0; n_ack = 0; n_pop = 0; n_jump = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic run_until_reqs(input int n, input int budget, input string tag);
    int c = 0;
    while (req_log.size() < n && c < budget) begin step(); c++; end
    check(tag, 32'(req_log.size()), 32'(n));
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    int c = 0;
    while (n_pop < n && c < budget) begin step(); c++; end
    check(tag, 32'(n_pop), 32'(n));
  endtask

  task automatic run_until_jump(input int budget, input string tag);
    int c = 0;
    while (n_jump == 0 && c < budget) begin step(); c++; end
    check(tag, 32'(n_jump), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = rand_plain();
    reset = 1'b1; ptr = '0; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    fixed_lat = 1; max_lat = 0; rand_ready = 0; pending = 0; lat_left = 0;
    occ = 0; exp_pc = 0; next_ptr = 0; req_addr = 0;
    clear_counts();

    // Reset values
    step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_is_jump", 32'(is_jump), 32'd0);
    step();
    reset = 1'b0;
    clear_counts();

    // 1: sequential fetch, ack one cycle after request
    instr_ready = 1'b1;
    run_until_reqs(3, 40, "s1_req_count");
    check("s1_addr0", req_log[0], 32'h0);
    check("s1_addr1", req_log[1], 32'h4);
    check("s1_addr2", req_log[2], 32'h8);
    run_until_pops(3, 40, "s1_pop_count");
    check("s1_pc_en_per_ack", 32'(n_push), 32'(n_ack));

    // 2: decode stalled fills the FIFO, then drains and fetch resumes at 0x10
    instr_ready = 1'b0;
    fixed_lat = 0;
    do_reset();
    repeat (30) step();
    check("s2_pushes", 32'(n_push), 32'd4);
    check("s2_mem_req_idle", 32'(mem_req), 32'd0);
    check("s2_valid", 32'(instr_valid), 32'd1);
    check("s2_head", instruction, mem[0]);
    req_log.delete();
    instr_ready = 1'b1;
    run_until_reqs(1, 20, "s2_resume_count");
    check("s2_resume_addr", req_log[0], 32'h10);

    // 3: J at 0x8 to 0x40
    mem[2] = 32'h0800_0010;
    fixed_lat = -1; max_lat = 2;
    do_reset();
    run_until_jump(60, "s3_jump_seen");
    req_log.delete();
    check("s3_fifo_empty", 32'(instr_valid), 32'd0);
    check("s3_jump_one_cycle", 32'(is_jump), 32'd0);
    run_until_reqs(1, 20, "s3_next_req");
    check("s3_target", req_log[0], 32'h40);

    // 4: jump popped while a slow response is outstanding
    mem[2] = rand_plain();
    mem[1] = 32'h0800_0020;
    fixed_lat = 3;
    instr_ready = 1'b0;
    do_reset();
    run_until_reqs(3, 40, "s4_req_count");
    check("s4_third_req", req_log[2], 32'h8);
    instr_ready = 1'b1;
    req_log.delete();
    run_until_reqs(1, 30, "s4_next_req");
    check("s4_no_pc_en_on_discard", 32'(n_push), 32'd2);
    check("s4_jump_count", 32'(n_jump), 32'd1);
    check("s4_target", req_log[0], 32'h80);

    // 5: JAL at 0x0 (target 0x80)
    mem[1] = rand_plain();
    mem[0] = 32'h0C00_0020;
    fixed_lat = 1;
    do_reset();
    run_until_pops(1, 20, "s5_pop");
    check("s5_jal_is_jump", 32'(n_jump), JAL_EN ? 32'd1 : 32'd0);
    run_until_reqs(2, 20, "s5_req_count");
    check("s5_next_addr", req_log[1], JAL_EN ? 32'h80 : 32'h4);

    // 6: reset while waiting for ack
    mem[0] = rand_plain();
    fixed_lat = 3;
    do_reset();
    run_until_reqs(1, 20, "s6_req");
    step();
    reset = 1'b1;
    step();
    check("s6_mem_req", 32'(mem_req), 32'd0);
    check("s6_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    clear_counts();
    run_until_reqs(1, 20, "s6_refetch_count");
    check("s6_refetch_addr", req_log[0], 32'h0);

    // Random program with jumps, random latency and decode backpressure
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 9) == 0)
        mem[i] = {($urandom_range(0, 1) != 0) ? 6'd2 : 6'd3, 26'($urandom_range(0, 255))};
      else
        mem[i] = rand_plain();
    end
    fixed_lat = -1; max_lat = 4; rand_ready = 1;
    do_reset();
    repeat (3000) step();
    rand_ready = 0;
    check("rand_progress", 32'(n_pop > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
